// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/func
// constants, ALU control codes and datapath mux-select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JR     = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  function automatic logic [3:0] alu_from_func(input logic [5:0] func);
    case (func)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      FN_NOR:  return ALU_NOR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_mem_wait.sv
// Memory access wait counter: counts cycles spent in a memory state and flags the
// access-done cycle, either after MEM_LATENCY cycles or on the memory ready strobe.
module mips_mem_wait #(
  parameter int MEM_LATENCY = 1,
  parameter bit USE_READY   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic cnt_en,
  input  logic cnt_clr,
  input  logic mem_ready_in,
  output logic done
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  logic [3:0] wait_cnt;

  // Saturates so a long ready wait never wraps back onto the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (cnt_clr) begin
      wait_cnt <= 4'd0;
    end else if (cnt_en && (wait_cnt != 4'hF)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign done = cnt_en & (USE_READY ? mem_ready_in : (wait_cnt == CNT_LAST));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM driving the shared-ALU/shared-memory datapath.
// Optional MIPS_CTRL_ILLEGAL_TRAP_EN: unsupported op/func enters TRAP and adds illegal_out.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter bit USE_READY   = 1'b0,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_in,
  input  logic [5:0]         func_in,
  input  logic               mem_ready_in,
  output logic               pcWrite_out,
  output logic               pcWriteCond_out,
  output logic               bne_out,
  output logic               iorD_out,
  output logic               memRead_out,
  output logic               memWrite_out,
  output logic               irWrite_out,
  output logic               memToReg_out,
  output logic               regDst_out,
  output logic               regWrite_out,
  output logic               ALUSrcA_out,
  output logic [1:0]         ALUSrcB_out,
  output logic [3:0]         ALUCntrl_out,
  output logic               extCntrl_out,
  output logic [1:0]         pcSource_out,
  output logic               instr_done_out,
  output logic [STATE_W-1:0] state_out
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_out
`endif
);

  state_t state, state_next;
  logic   mem_done, wait_en, wait_clr, illegal;
  logic   pc_write, pc_write_cond, mem_write, ir_write, reg_write, instr_done;

  assign wait_en  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_clr = (state_next != state);

  mips_mem_wait #(
    .MEM_LATENCY(MEM_LATENCY),
    .USE_READY  (USE_READY)
  ) u_mem_wait (
    .clk         (clk),
    .reset       (reset),
    .cnt_en      (wait_en),
    .cnt_clr     (wait_clr),
    .mem_ready_in(mem_ready_in),
    .done        (mem_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    bne_out       = 1'b0;
    iorD_out      = 1'b0;
    memRead_out   = 1'b0;
    memToReg_out  = 1'b0;
    regDst_out    = 1'b0;
    ALUSrcA_out   = 1'b0;
    ALUSrcB_out   = SRCB_B;
    ALUCntrl_out  = ALU_AND;
    extCntrl_out  = 1'b0;
    pcSource_out  = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        memRead_out  = 1'b1;
        ALUSrcB_out  = SRCB_4;
        ALUCntrl_out = ALU_ADD;
        if (mem_done) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB_out  = SRCB_IMM_SH2;
        ALUCntrl_out = ALU_ADD;
        extCntrl_out = 1'b1;
        case (op_in)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            case (func_in)
              FN_JR:                          state_next = S_JR;
              FN_ADD, FN_SUB, FN_SLT, FN_NOR: state_next = S_REXEC;
              FN_NOP: begin
                state_next = S_FETCH;
                instr_done = 1'b1;
              end
              default: illegal = 1'b1;
            endcase
          end
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_J:                     state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_LUI: state_next = S_IEXEC;
          default:                  illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_FETCH;
          instr_done = 1'b1;
`endif
        end
      end
      S_MEMADR: begin
        ALUSrcA_out  = 1'b1;
        ALUSrcB_out  = SRCB_IMM;
        ALUCntrl_out = ALU_ADD;
        extCntrl_out = 1'b1;
        state_next   = (op_in == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memRead_out = 1'b1;
        iorD_out    = 1'b1;
        if (mem_done) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        memToReg_out = 1'b1;
        instr_done   = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iorD_out  = 1'b1;
        if (mem_done) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_REXEC: begin
        ALUSrcA_out  = 1'b1;
        ALUCntrl_out = alu_from_func(func_in);
        state_next   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        regDst_out = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_out   = 1'b1;
        ALUCntrl_out  = ALU_SUB;
        pc_write_cond = 1'b1;
        pcSource_out  = PCSRC_ALUOUT;
        bne_out       = (op_in == OP_BNE);
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pcSource_out = PCSRC_JUMP;
        instr_done   = 1'b1;
        state_next   = S_FETCH;
      end
      S_JR: begin
        pc_write     = 1'b1;
        pcSource_out = PCSRC_REG;
        instr_done   = 1'b1;
        state_next   = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA_out = 1'b1;
        ALUSrcB_out = SRCB_IMM;
        case (op_in)
          OP_ADDI: begin
            ALUCntrl_out = ALU_ADD;
            extCntrl_out = 1'b1;
          end
          OP_ANDI: ALUCntrl_out = ALU_AND;
          OP_LUI:  ALUCntrl_out = ALU_LUI;
          default: ALUCntrl_out = ALU_AND;
        endcase
        state_next = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is held so an abandoned access never writes.
  assign pcWrite_out     = pc_write & ~reset;
  assign pcWriteCond_out = pc_write_cond & ~reset;
  assign memWrite_out    = mem_write & ~reset;
  assign irWrite_out     = ir_write & ~reset;
  assign regWrite_out    = reg_write & ~reset;
  assign instr_done_out  = instr_done & ~reset;
  assign state_out       = STATE_W'(state);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_out = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: three instances (latency 1, ready
// handshake, latency 4); the one under test is selected while the others sit in reset.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    state_t      st;
    logic [21:0] ctl;
    logic        rdy;
  } rec_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic [5:0]  op, func;
  logic        mem_ready;
  int          sel;
  logic [21:0] obs_ctl;
  logic [3:0]  obs_st;
  rec_t        sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [21:0] ctl;
    logic [3:0]  st;
    mips_multicycle_control #(
      .MEM_LATENCY((g == 2) ? 4 : 1),
      .USE_READY  (g == 1),
      .STATE_W    (4)
    ) u_dut (
      .clk            (clk),
      .reset          (rst_v[g]),
      .op_in          (op),
      .func_in        (func),
      .mem_ready_in   (mem_ready),
      .pcWrite_out    (ctl[20]),
      .pcWriteCond_out(ctl[19]),
      .bne_out        (ctl[18]),
      .iorD_out       (ctl[17]),
      .memRead_out    (ctl[16]),
      .memWrite_out   (ctl[15]),
      .irWrite_out    (ctl[14]),
      .memToReg_out   (ctl[13]),
      .regDst_out     (ctl[12]),
      .regWrite_out   (ctl[11]),
      .ALUSrcA_out    (ctl[10]),
      .ALUSrcB_out    (ctl[9:8]),
      .ALUCntrl_out   (ctl[7:4]),
      .extCntrl_out   (ctl[3]),
      .pcSource_out   (ctl[2:1]),
      .instr_done_out (ctl[0]),
      .state_out      (st)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      ,
      .illegal_out    (ctl[21])
`endif
    );
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign ctl[21] = 1'b0;
`endif
  end

  always_comb begin
    obs_ctl = g_dut[0].ctl;
    obs_st  = g_dut[0].st;
    case (sel)
      1: begin obs_ctl = g_dut[1].ctl; obs_st = g_dut[1].st; end
      2: begin obs_ctl = g_dut[2].ctl; obs_st = g_dut[2].st; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: return (f == 6'h20) || (f == 6'h22) || (f == 6'h2A) || (f == 6'h27) ||
                    (f == 6'h08) || (f == 6'h00);
      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word: {illegal, pcW, pcWC, bne, iorD, mRd, mWr, irW, m2r, rDst, rW,
  // srcA, srcB[2], alu[4], ext, pcSrc[2], done}
  function automatic logic [21:0] mk_ctl(input state_t s, input logic [5:0] o,
                                         input logic [5:0] f, input bit last);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ext, done, ill;
    logic [1:0] srcb, pcs;
    logic [3:0] alu;
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ext, done} = 13'd0;
    srcb = 2'b00; pcs = 2'b00; alu = 4'b0000;
    ill = (s == S_TRAP);
    case (s)
      S_FETCH:  begin mrd = 1; srcb = 2'b01; alu = 4'b0010; irw = last; pcw = last; end
      S_DECODE: begin
        srcb = 2'b11; alu = 4'b0010; ext = 1;
        done = ((o == 6'h00) && (f == 6'h00)) || (!TRAP_EN && !is_legal(o, f));
      end
      S_MEMADR: begin srca = 1; srcb = 2'b10; alu = 4'b0010; ext = 1; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; done = last; end
      S_REXEC:  begin
        srca = 1;
        case (f)
          6'h20: alu = 4'b0010;
          6'h22: alu = 4'b0110;
          6'h2A: alu = 4'b0111;
          6'h27: alu = 4'b1100;
          default: alu = 4'b0000;
        endcase
      end
      S_RWB:    begin rw = 1; rdst = 1; done = 1; end
      S_BRANCH: begin srca = 1; alu = 4'b0110; pcwc = 1; pcs = 2'b01; bne = (o == 6'h05); done = 1; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
      S_JR:     begin pcw = 1; pcs = 2'b11; done = 1; end
      S_IEXEC:  begin
        srca = 1; srcb = 2'b10;
        if (o == 6'h08) begin alu = 4'b0010; ext = 1; end
        else if (o == 6'h0F) alu = 4'b1111;
      end
      S_IWB:    begin rw = 1; done = 1; end
      default: ;
    endcase
    return {ill, pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, alu, ext, pcs, done};
  endfunction

  task automatic push(input state_t s, input logic [5:0] o, input logic [5:0] f,
                      input bit last, input bit rdy);
    rec_t r;
    r.st = s; r.ctl = mk_ctl(s, o, f, last); r.rdy = rdy;
    sb_q.push_back(r);
  endtask

  // Ready mode strobes ready only on the final cycle; fixed mode strobes it early to show it is ignored.
  task automatic push_mem(input state_t s, input logic [5:0] o, input logic [5:0] f,
                          input int n, input bit use_rdy);
    for (int i = 0; i < n; i++)
      push(s, o, f, i == n - 1, use_rdy ? (i == n - 1) : (i == 0));
  endtask

  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input int n, input bit use_rdy);
    push_mem(S_FETCH, o, f, n, use_rdy);
    push(S_DECODE, o, f, 1'b0, 1'b1);
    if (!is_legal(o, f)) begin
      if (TRAP_EN) for (int i = 0; i < 3; i++) push(S_TRAP, o, f, 1'b0, 1'b1);
    end else begin
      case (o)
        6'h23: begin
          push(S_MEMADR, o, f, 1'b0, 1'b1);
          push_mem(S_MEMRD, o, f, n, use_rdy);
          push(S_MEMWB, o, f, 1'b0, 1'b1);
        end
        6'h2B: begin
          push(S_MEMADR, o, f, 1'b0, 1'b1);
          push_mem(S_MEMWR, o, f, n, use_rdy);
        end
        6'h00: begin
          if (f == 6'h08) push(S_JR, o, f, 1'b0, 1'b1);
          else if (f != 6'h00) begin
            push(S_REXEC, o, f, 1'b0, 1'b1);
            push(S_RWB, o, f, 1'b0, 1'b1);
          end
        end
        6'h04, 6'h05: push(S_BRANCH, o, f, 1'b0, 1'b1);
        6'h02: push(S_JUMP, o, f, 1'b0, 1'b1);
        default: begin
          push(S_IEXEC, o, f, 1'b0, 1'b1);
          push(S_IWB, o, f, 1'b0, 1'b1);
        end
      endcase
    end
  endtask

  // Entered and left on a falling edge; compares 1 ns later.
  task automatic run(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = sb_q.pop_front();
      mem_ready = r.rdy;
      #1;
      chk($sformatf("state[op%h fn%h]", op, func), {28'd0, obs_st}, {28'd0, r.st});
      chk($sformatf("ctl[op%h fn%h st%0d]", op, func, r.st), {10'd0, obs_ctl}, {10'd0, r.ctl});
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int n, input bit use_rdy);
    op = o; func = f;
    push_instr(o, f, n, use_rdy);
    run(sb_q.size());
  endtask

  task automatic rst_pulse(input int g);
    rst_v[g] = 1'b1;
    #1;
    chk("rst_state", {28'd0, obs_st}, {28'd0, S_FETCH});
    chk("rst_ctl", {10'd0, obs_ctl}, {10'd0, mk_ctl(S_FETCH, 6'h00, 6'h00, 1'b0)});
    @(negedge clk);
    rst_v[g] = 1'b0;
  endtask

  logic [11:0] tbl0 [14] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h27},
    {6'h08, 6'h00}, {6'h0C, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
    {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
    {6'h00, 6'h08}, {6'h00, 6'h00}
  };

  initial begin
    rst_v = 3'b111; op = 6'h00; func = 6'h00; mem_ready = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {28'd0, obs_st}, {28'd0, S_FETCH});
    chk("reset_ctl", {10'd0, obs_ctl}, {10'd0, mk_ctl(S_FETCH, 6'h00, 6'h00, 1'b0)});
    @(negedge clk);
    rst_v[0] = 1'b0;

    for (int i = 0; i < 14; i++) begin
      logic [11:0] e;
      e = tbl0[i];
      do_instr(e[11:6], e[5:0], 1, 1'b0);
    end
    do_instr(6'h3F, 6'h00, 1, 1'b0);
    rst_pulse(0);
    do_instr(6'h00, 6'h21, 1, 1'b0);
    rst_pulse(0);

    rst_v[0] = 1'b1; sel = 1; rst_v[1] = 1'b0;
    do_instr(6'h23, 6'h00, 3, 1'b1);
    do_instr(6'h2B, 6'h00, 2, 1'b1);
    do_instr(6'h00, 6'h20, 1, 1'b1);
    do_instr(6'h04, 6'h00, 2, 1'b1);

    rst_v[1] = 1'b1; sel = 2; rst_v[2] = 1'b0;
    do_instr(6'h00, 6'h20, 4, 1'b0);
    op = 6'h2B; func = 6'h00;
    push_instr(6'h2B, 6'h00, 4, 1'b0);
    run(7);
    sb_q.delete();
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_state", {28'd0, obs_st}, {28'd0, S_MEMWR});
    chk("pre_rst_memwrite", {31'd0, obs_ctl[15]}, 32'd1);
    #1;
    rst_v[2] = 1'b1;
    #1;
    chk("mid_rst_state", {28'd0, obs_st}, {28'd0, S_FETCH});
    chk("mid_rst_memwrite", {31'd0, obs_ctl[15]}, 32'd0);
    chk("mid_rst_ctl", {10'd0, obs_ctl}, {10'd0, mk_ctl(S_FETCH, 6'h00, 6'h00, 1'b0)});
    @(negedge clk);
    rst_v[2] = 1'b0;
    do_instr(6'h00, 6'h20, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
